// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency busy sequencing and HI/LO commit.
// Optional MDU_FLUSH_EN macro adds a flush input that aborts an op in flight.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_is_md,
`ifdef MDU_FLUSH_EN
   input  logic        flush,
`endif
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] res_q, res_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        flush_w;

`ifdef MDU_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
      logic [63:0] xe, ye;
      xe = sgn ? {{32{x[31]}}, x} : {32'b0, x};
      ye = sgn ? {{32{y[31]}}, y} : {32'b0, y};
      return xe * ye;
   endfunction

   // Magnitude division keeps 0x80000000 / -1 well defined: quotient bits 0x80000000, rem 0.
   function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
      logic        xn, yn;
      logic [31:0] xm, ym, q, r;
      xn = sgn & x[31];
      yn = sgn & y[31];
      xm = xn ? (~x + 32'd1) : x;
      ym = yn ? (~y + 32'd1) : y;
      q  = xm / ym;
      r  = xm % ym;
      if (xn ^ yn) q = ~q + 32'd1;
      if (xn)      r = ~r + 32'd1;
      return {r, q};
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush_w) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     res_d   = mul64(a, b, op == OP_MULT);
                     cnt_d   = 4'(MULT_CYCLES);
                     state_d = ST_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged.
                     res_d   = (b == 32'd0) ? {hi_q, lo_q} : div64(a, b, op == OP_DIV);
                     cnt_d   = 4'(DIV_CYCLES);
                     state_d = ST_BUSY;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            if (flush_w) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  {hi_d, lo_d} = res_q;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         res_q   <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy      = (state_q == ST_BUSY);
   assign stall_req = d_is_md & (busy | start);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pushed at issue, popped at completion.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        d_is_md;
`ifdef MDU_FLUSH_EN
   logic        flush;
`endif
   logic        busy, stall_req;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .d_is_md(d_is_md),
`ifdef MDU_FLUSH_EN
      .flush(flush),
`endif
      .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse at a falling edge; returns at the falling edge after the start edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int cnt;
      logic [63:0] e;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
      if (exp_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_hilo"}, {hi, lo}, e);
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; d_is_md = 1'b0;
`ifdef MDU_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_stall", 64'(stall_req), 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);

      exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
      issue(3'd1, 32'hFFFFFFFE, 32'd3);
      wait_done(5, "mult");

      exp_q.push_back(64'h00000002_FFFFFFFA);
      issue(3'd2, 32'hFFFFFFFE, 32'd3);
      wait_done(5, "multu");

      exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_done(10, "div_neg");

      exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
      issue(3'd4, 32'd7, 32'd0);
      wait_done(10, "divu_by0");

      exp_q.push_back(64'h00000000_80000000);
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_done(10, "div_ovf");

      // MTHI then MTLO on consecutive cycles
      start = 1'b1; op = 3'd5; a = 32'h12345678;
      @(negedge clk);
      chk("mthi_hi", 64'(hi), 64'h12345678);
      chk("mthi_busy", 64'(busy), 64'd0);
      op = 3'd6; a = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
      chk("mtlo_hi_kept", 64'(hi), 64'h12345678);
      chk("mtlo_busy", 64'(busy), 64'd0);

      // Stall request and ignored start while busy
      d_is_md = 1'b1;
      start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
      #1;
      chk("stall_on_start", 64'(stall_req), 64'd1);
      exp_q.push_back(64'h00000000_0000002A);
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         chk("stall_in_busy", 64'(stall_req), 64'd1);
         cnt++;
         if (cnt == 2) begin
            start = 1'b1; op = 3'd1; a = 32'd100; b = 32'd100;
         end
         @(negedge clk);
         start = 1'b0; op = 3'd0;
      end
      chk("stall_busy_cycles", 64'(cnt), 64'd5);
      chk("stall_released", 64'(stall_req), 64'd0);
      chk("ignored_start_busy", 64'(busy), 64'd0);
      chk("ignored_start_hilo", {hi, lo}, exp_q.pop_front());
      d_is_md = 1'b0;

      // Back-to-back: issued on the first non-busy cycle
      exp_q.push_back(64'h00000003_00000000);
      issue(3'd2, 32'h00010000, 32'h00030000);
      wait_done(5, "b2b_multu");

      // Reset during busy cycle 3 of a DIV
      issue(3'd3, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("rst_after_busy", 64'(busy), 64'd0);
      chk("rst_after_hilo", {hi, lo}, 64'd0);

`ifdef MDU_FLUSH_EN
      issue(3'd1, 32'd6, 32'd7);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);
      chk("flush_hilo", {hi, lo}, 64'd0);
      flush = 1'b1;
      issue(3'd5, 32'hDEADBEEF, 32'd0);
      flush = 1'b0;
      chk("flush_mthi", 64'(hi), 64'd0);
      chk("flush_mthi_busy", 64'(busy), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the 5-stage MIPS pipeline. It sits beside the E-stage ALU, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, and sequences a fixed-latency busy period before committing results to the architectural HI/LO registers. It raises the stall request that freezes D-stage MDU instructions while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MDU op this cycle
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- a  in  32  rs operand (E stage, forwarded)
- b  in  32  rt operand (E stage, forwarded)
- d_is_md  in  1  D-stage instruction is any MDU op (incl. MFHI/MFLO)
- busy  out  1  operation in flight
- stall_req  out  1  freeze D stage
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, BUSY. 4-bit down-counter cnt; 64-bit result shadow res.
- Reset: state IDLE, cnt 0, res 0, hi 0, lo 0; busy 0, stall_req 0 (given d_is_md/start low).
- IDLE, start=1, op MULT/MULTU/DIV/DIVU: latch res, load cnt with MULT_CYCLES or DIV_CYCLES, go BUSY.
- IDLE, start=1, op MTHI: hi <= a; MTLO: lo <= a. No BUSY.
- IDLE, start=1, op NONE/7, or start=0: no change.
- BUSY: cnt decrements each edge; on the edge where cnt goes 1->0: {hi,lo} <= res, go IDLE.
- start while BUSY: ignored entirely (upstream must not issue; stall_req guarantees this).
- busy = (state == BUSY). Registered.
- stall_req = d_is_md & (busy | start). Combinational.
- Arithmetic:
  - MULT: signed 32x32->64, hi=upper, lo=lower. MULTU: unsigned.
  - DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of a. DIVU: unsigned.
  - b == 0 (DIV/DIVU): busy sequence runs normally, hi/lo left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset asserted mid-BUSY: immediate abort, no commit, hi/lo 0.

## Timing
- Start edge T0: busy high in cycles T0+1 .. T0+N (N = MULT_CYCLES or DIV_CYCLES), low at T0+N+1.
- New hi/lo visible from the cycle busy first reads 0 (edge T0+N).
- MTHI/MTLO: value visible one cycle after the start edge; busy stays 0.
- stall_req asserts in the same cycle as start when d_is_md=1 (back-to-back MDU ops stall).
- Back-to-back: a new start is accepted in the first cycle busy reads 0.

## Configuration
- MDU_FLUSH_EN defined: adds input `flush` (1 bit). flush=1 in BUSY: next edge -> IDLE, cnt 0, no commit, hi/lo unchanged. flush=1 with start in IDLE: start ignored (MTHI/MTLO also suppressed). flush has priority over commit on the final edge.
- MDU_FLUSH_EN undefined: no flush port; every accepted op completes.

## Test plan
- Reset then MULT a=0xFFFFFFFE, b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle later each, busy never high.
- MULT issued, d_is_md=1 throughout -> stall_req high from start cycle through last busy cycle, low after; second start during busy ignored (hi/lo match first op only).
- Reset asserted at busy cycle 3 of DIV -> busy, hi, lo go 0 immediately and stay 0 after release.
- (MDU_FLUSH_EN) flush at busy cycle 4 of MULT 6x7 -> busy low next cycle, hi/lo retain prior values 0/0.
